add16_seq: RTL and testbench
============================

ADD16_SEQ -- requirements
Module: add16_seq

Interface
REQ-001 Parameter NIB, default 4, number of 4-bit nibbles per operand; operand width W = 4*NIB.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start_valid  input  1  requester offers an operation.
REQ-005 start_ready  output  1  block can accept an operation; high exactly when state is IDLE.
REQ-006 a  input  W  operand A, sampled only on acceptance.
REQ-007 b  input  W  operand B, sampled only on acceptance.
REQ-008 cin  input  1  carry-in, sampled only on acceptance.
REQ-009 abort  input  1  cancels an operation in progress.
REQ-010 busy  output  1  high while state is RUN.
REQ-011 sum  output  W  registered result of the last completed operation.
REQ-012 cout  output  1  registered carry-out of the last completed operation.
REQ-013 ovf  output  1  registered signed overflow of the last completed operation.
REQ-014 done  output  1  registered one-cycle pulse marking a new result on sum/cout/ovf.

Function
REQ-015 The block SHALL compute A+B+cin serially with a single 4-bit adder datapath, one nibble per cycle, LSB nibble first.
REQ-016 States SHALL be IDLE and RUN only.
REQ-017 Acceptance: start_valid && start_ready at a rising edge; latches a, b, cin into internal operand registers, clears nibble index to 0, enters RUN.
REQ-018 start_valid while not in IDLE SHALL be ignored; a, b, cin changes after acceptance SHALL NOT affect the result.
REQ-019 Each RUN cycle: 5-bit add of A nibble[idx] + B nibble[idx] + carry register; low 4 bits into internal result nibble[idx], bit 4 into carry register, idx increments.
REQ-020 On the edge processing nibble NIB-1: sum <= full internal result, cout <= final carry, ovf <= (A[W-1]==B[W-1]) && (result[W-1]!=A[W-1]), done <= 1, state <= IDLE.
REQ-021 Latency: operation accepted at edge k SHALL assert done, sum, cout, ovf valid in the cycle following edge k+NIB (NIB=4: edge k+4).
REQ-022 done SHALL be high for exactly one cycle per completed operation; cleared on every other edge.
REQ-023 sum, cout, ovf SHALL hold their values until the next completion or reset; no intermediate values visible.
REQ-024 Back-to-back: in the done cycle start_ready is high; an operation accepted then proceeds with no bubble.
REQ-025 abort high at an edge while in RUN: state <= IDLE, no done, sum/cout/ovf unchanged; abort takes priority over completion on the last nibble edge.
REQ-026 abort in IDLE SHALL have no effect and SHALL NOT block a simultaneous acceptance.
REQ-027 Carry SHALL ripple across nibbles; all arithmetic modulo 2^W with carry beyond bit W-1 reported only on cout.

Reset
REQ-028 rst high at an edge SHALL force state IDLE, idx 0, carry 0, sum 0, cout 0, ovf 0, done 0; start_ready high and busy low in the following cycle.
REQ-029 rst SHALL take priority over acceptance, abort and completion, including mid-RUN; an interrupted operation produces no done.

Verification
REQ-030 Reset: rst high 2 cycles -> sum=0x0000, cout=0, ovf=0, done=0, busy=0, start_ready=1.
REQ-031 a=0x1234, b=0x4321, cin=0 accepted edge k -> busy edges k..k+3, done pulse after edge k+4, sum=0x5555, cout=0, ovf=0.
REQ-032 a=0xFFFF, b=0x0000, cin=1 -> full ripple, sum=0x0000, cout=1, ovf=0.
REQ-033 a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; then a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
REQ-034 After a result of 0x8000, accept a=0x0101, b=0x0101, abort at edge k+2 -> no done, sum stays 0x8000, start_ready=1 next cycle; same with rst at k+2 -> sum=0x0000, no done.
REQ-035 start_valid held high with new operands in the done cycle -> second operation accepted at that edge, second done exactly 4 cycles after the first, each result correct; a/b changed during RUN do not alter the result.

Source files
------------

// File: rtl/add16_seq.sv
// Serial nibble-wide adder: computes a + b + cin one 4-bit slice per cycle, LSB first,
// through a single 4-bit adder. Results are registered and flagged by a one-cycle done pulse.
module add16_seq #(
  parameter int unsigned NIB = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [4*NIB-1:0] a,
  input  logic [4*NIB-1:0] b,
  input  logic             cin,
  input  logic             abort,
  output logic             busy,
  output logic [4*NIB-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             done
);

  localparam int unsigned W  = 4 * NIB;
  localparam int unsigned IW = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic StIdle = 1'b0;
  localparam logic StRun  = 1'b1;

  logic          r_state;
  logic [IW-1:0] r_idx;
  logic          r_carry;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_res;
  logic [W-1:0]  r_sum;
  logic          r_cout;
  logic          r_ovf;
  logic          r_done;

  logic [3:0]    w_a_nib;
  logic [3:0]    w_b_nib;
  logic [4:0]    w_nib_sum;
  logic [W-1:0]  w_res_next;
  logic          w_last;
  logic          w_ovf;

  // Single 4-bit slice; the carry register links consecutive nibbles.
  always_comb begin
    w_a_nib   = r_a[r_idx*4 +: 4];
    w_b_nib   = r_b[r_idx*4 +: 4];
    w_nib_sum = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, r_carry};
  end

  // Full result including the nibble produced this cycle, so the final edge can publish it.
  always_comb begin
    w_res_next                 = r_res;
    w_res_next[r_idx*4 +: 4]   = w_nib_sum[3:0];
  end

  assign w_last = (r_idx == IW'(NIB - 1));
  assign w_ovf  = (r_a[W-1] == r_b[W-1]) && (w_res_next[W-1] != r_a[W-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          // abort is meaningless here and must not block an acceptance.
          if (start_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_res   <= '0;
            r_state <= StRun;
          end
        end
        StRun: begin
          if (abort) begin
            r_state <= StIdle;
          end else begin
            r_res   <= w_res_next;
            r_carry <= w_nib_sum[4];
            r_idx   <= r_idx + 1'b1;
            if (w_last) begin
              r_sum   <= w_res_next;
              r_cout  <= w_nib_sum[4];
              r_ovf   <= w_ovf;
              r_done  <= 1'b1;
              r_state <= StIdle;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign start_ready = (r_state == StIdle);
  assign busy        = (r_state == StRun);
  assign sum         = r_sum;
  assign cout        = r_cout;
  assign ovf         = r_ovf;
  assign done        = r_done;

endmodule

// File: tb/tb_add16_seq.sv
// Directed self-checking bench for add16_seq with hand-computed results.
module tb_add16_seq;

  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         abort;
  logic         busy;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         done;

  int n_chk = 0;
  int n_err = 0;

  add16_seq #(.NIB(NIB)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .abort       (abort),
    .busy        (busy),
    .sum         (sum),
    .cout        (cout),
    .ovf         (ovf),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation, scramble operands during RUN, check timing and result.
  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic op_cin,
                        input logic abort_at_accept, input logic [W-1:0] exp_sum,
                        input logic exp_cout, input logic exp_ovf, input string tag);
    check_eq({tag, "_ready"}, start_ready, 1'b1);
    start_valid = 1'b1;
    a           = op_a;
    b           = op_b;
    cin         = op_cin;
    abort       = abort_at_accept;
    step();
    start_valid = 1'b0;
    abort       = 1'b0;
    a           = ~op_a;
    b           = op_b ^ 16'h5A5A;
    cin         = ~op_cin;
    for (int i = 0; i < int'(NIB); i++) begin
      check_eq({tag, "_busy"}, busy, 1'b1);
      check_eq({tag, "_nodone"}, done, 1'b0);
      step();
    end
    check_eq({tag, "_done"}, done, 1'b1);
    check_eq({tag, "_idle"}, busy, 1'b0);
    check_eq({tag, "_sum"}, sum, exp_sum);
    check_eq({tag, "_cout"}, cout, exp_cout);
    check_eq({tag, "_ovf"}, ovf, exp_ovf);
    step();
    check_eq({tag, "_pulse"}, done, 1'b0);
    check_eq({tag, "_hold"}, sum, exp_sum);
  endtask

  initial begin
    rst = 1'b1; start_valid = 1'b0; a = '0; b = '0; cin = 1'b0; abort = 1'b0;
    step();
    step();
    rst = 1'b0;
    check_eq("rst_sum", sum, 16'h0000);
    check_eq("rst_cout", cout, 1'b0);
    check_eq("rst_ovf", ovf, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_ready", start_ready, 1'b1);

    // abort held at the acceptance edge in IDLE must not block it
    run_op(16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0, "basic");
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple");
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "posovf");
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "negovf");
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "pre_abort");

    // Abort at edge k+2
    start_valid = 1'b1; a = 16'h0101; b = 16'h0101; cin = 1'b0;
    step();
    start_valid = 1'b0;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("abort_ready", start_ready, 1'b1);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_sum", sum, 16'h8000);
    for (int i = 0; i < int'(NIB); i++) begin
      check_eq("abort_nodone", done, 1'b0);
      step();
    end
    check_eq("abort_hold", sum, 16'h8000);

    // Reset at edge k+2
    start_valid = 1'b1; a = 16'h0101; b = 16'h0101; cin = 1'b0;
    step();
    start_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mrst_ready", start_ready, 1'b1);
    check_eq("mrst_busy", busy, 1'b0);
    check_eq("mrst_sum", sum, 16'h0000);
    for (int i = 0; i < int'(NIB); i++) begin
      check_eq("mrst_nodone", done, 1'b0);
      step();
    end

    // Back-to-back: second op offered in the done cycle of the first
    start_valid = 1'b1; a = 16'h0F0F; b = 16'h0101; cin = 1'b0;
    step();
    start_valid = 1'b0;
    for (int i = 0; i < int'(NIB); i++) begin
      a = 16'hAAAA; b = 16'h5555;
      step();
    end
    check_eq("b2b_done1", done, 1'b1);
    check_eq("b2b_sum1", sum, 16'h1010);
    check_eq("b2b_ready", start_ready, 1'b1);
    start_valid = 1'b1; a = 16'h8000; b = 16'hFFFF; cin = 1'b0;
    step();
    start_valid = 1'b0; a = 16'h0000; b = 16'h0000; cin = 1'b1;
    check_eq("b2b_busy2", busy, 1'b1);
    check_eq("b2b_hold1", sum, 16'h1010);
    for (int i = 1; i <= int'(NIB); i++) begin
      if (i == 2) begin
        start_valid = 1'b1;
        a = 16'h1111;
      end
      step();
      check_eq((i < int'(NIB)) ? "b2b_early" : "b2b_done2", done, (i == int'(NIB)));
    end
    start_valid = 1'b0;
    check_eq("b2b_sum2", sum, 16'h7FFF);
    check_eq("b2b_cout2", cout, 1'b1);
    check_eq("b2b_ovf2", ovf, 1'b1);
    step();
    check_eq("b2b_pulse2", done, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
